round_norm_pipe: RTL and testbench

Parametrised rounding and renormalisation stage for the posit arithmetic datapath, the successor to the fixed 64→32 rounding block. It takes a wide shifted mantissa with its regime (k), exponent and sign, and rounds it to a configurable output width under one of four selectable rounding modes. Mantissa carry-out is propagated into the exponent and then into the regime, with saturation at the maximum regime. Input and output use valid/ready handshakes, so the block sits between the multiply/align stage and the posit encoder and tolerates back-pressure.

---
 rtl/posit_pkg.sv | 22 ++
 rtl/round_inc_dec.sv | 25 ++
 rtl/round_norm_pipe.sv | 158 +++++++++++++++
 tb/tb_round_norm_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared definitions for the posit datapath: rounding-mode codes, the
// round/renormalise FSM encoding and the maximum-regime derivation.
package posit_pkg;

  // Rounding modes, sampled with each operand
  localparam logic [1:0] RND_RNE = 2'd0;  // nearest, ties to even
  localparam logic [1:0] RND_RTZ = 2'd1;  // toward zero
  localparam logic [1:0] RND_RUP = 2'd2;  // toward +inf
  localparam logic [1:0] RND_RDN = 2'd3;  // toward -inf

  // Round/renormalise FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUND  = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Largest positive value of a signed k_w-bit regime
  function automatic int unsigned k_max(input int unsigned k_w);
    return (32'd1 << (k_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/round_inc_dec.sv
// Rounding increment decision from lsb/guard/sticky, sign and mode.
// Ports: i_lsb, i_guard, i_sticky, i_sign, i_mode -> o_inc_c (combinational).
module round_inc_dec
  import posit_pkg::*;
(
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_sticky,
  input  logic       i_sign,
  input  logic [1:0] i_mode,
  output logic       o_inc_c
);

  always_comb begin
    o_inc_c = 1'b0;
    case (i_mode)
      RND_RNE: o_inc_c = i_guard & (i_sticky | i_lsb);
      RND_RTZ: o_inc_c = 1'b0;
      RND_RUP: o_inc_c = (i_guard | i_sticky) & ~i_sign;
      RND_RDN: o_inc_c = (i_guard | i_sticky) & i_sign;
      default: o_inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/round_norm_pipe.sv
// Rounds a wide MSB-aligned mantissa to OUT_W bits, then propagates any
// carry into exponent and regime, saturating at the maximum regime.
// Ports: clk, rst_n; in_valid/in_ready with shifted_mantissa, k_in, exp_in,
// sign_in, rnd_mode; out_valid/out_ready with mantissa_out, k_final,
// exp_final, sign_final, inexact, sat. in_ready decodes state==IDLE.
module round_norm_pipe
  import posit_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned ES    = 3,
  parameter int unsigned K_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  shifted_mantissa,
  input  logic [K_W-1:0]   k_in,
  input  logic [ES-1:0]    exp_in,
  input  logic             sign_in,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] mantissa_out,
  output logic [K_W-1:0]   k_final,
  output logic [ES-1:0]    exp_final,
  output logic             sign_final,
  output logic             inexact,
  output logic             sat
);

  localparam int unsigned SUM_W = OUT_W + 1;
  localparam logic [K_W-1:0] K_MAX_V = K_W'(k_max(K_W));

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [IN_W-1:0]  r_sm;
  logic [K_W-1:0]   r_k;
  logic [ES-1:0]    r_exp;
  logic             r_sign;
  logic [1:0]       r_mode;
  logic [SUM_W-1:0] r_sum;
  logic             r_inexact_q;

  logic [OUT_W-1:0] w_kept;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;
  logic             w_exp_wrap;
  logic             w_k_ovf;
  logic [OUT_W-1:0] w_mant_adj;
  logic [ES-1:0]    w_exp_adj;
  logic [K_W-1:0]   w_k_adj;

  assign in_ready = (r_state == ST_IDLE);

  // Split the captured mantissa into kept bits, guard and sticky
  assign w_kept   = r_sm[IN_W-1 -: OUT_W];
  assign w_guard  = r_sm[IN_W-OUT_W-1];
  assign w_sticky = |r_sm[IN_W-OUT_W-2:0];

  round_inc_dec u_inc (
    .i_lsb    (w_kept[0]),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .i_sign   (r_sign),
    .i_mode   (r_mode),
    .o_inc_c  (w_inc)
  );

  assign w_sum = {1'b0, w_kept} + SUM_W'(w_inc);

  // Carry-out can only come from an all-ones mantissa, so the rounded
  // value is exactly 1.000..; it moves into the exponent, then the regime.
  assign w_carry    = r_sum[OUT_W];
  assign w_exp_wrap = w_carry & (r_exp == '1);
  assign w_k_ovf    = w_exp_wrap & (r_k == K_MAX_V);
  assign w_mant_adj = w_carry ? {1'b1, {(OUT_W-1){1'b0}}} : r_sum[OUT_W-1:0];
  assign w_exp_adj  = r_exp + ES'(w_carry);
  assign w_k_adj    = r_k + K_W'(w_exp_wrap);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_next = ST_ROUND;
      ST_ROUND:  w_next = ST_ADJUST;
      ST_ADJUST: w_next = ST_HOLD;
      ST_HOLD:   if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Operand capture, rounding sum and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sm         <= '0;
      r_k          <= '0;
      r_exp        <= '0;
      r_sign       <= 1'b0;
      r_mode       <= RND_RNE;
      r_sum        <= '0;
      r_inexact_q  <= 1'b0;
      out_valid    <= 1'b0;
      mantissa_out <= '0;
      k_final      <= '0;
      exp_final    <= '0;
      sign_final   <= 1'b0;
      inexact      <= 1'b0;
      sat          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sm   <= shifted_mantissa;
            r_k    <= k_in;
            r_exp  <= exp_in;
            r_sign <= sign_in;
            r_mode <= rnd_mode;
          end
        end
        ST_ROUND: begin
          r_sum       <= w_sum;
          r_inexact_q <= w_guard | w_sticky;
        end
        ST_ADJUST: begin
          out_valid  <= 1'b1;
          sign_final <= r_sign;
          inexact    <= r_inexact_q;
          sat        <= w_k_ovf;
          if (w_k_ovf) begin
            mantissa_out <= '1;
            exp_final    <= '1;
            k_final      <= K_MAX_V;
          end else begin
            mantissa_out <= w_mant_adj;
            exp_final    <= w_exp_adj;
            k_final      <= w_k_adj;
          end
        end
        ST_HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_round_norm_pipe.sv
// Directed bench for round_norm_pipe: rounding modes, carry chain,
// saturation, back-pressure and asynchronous reset.
module tb_round_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] shifted_mantissa;
  logic [5:0]  k_in;
  logic [2:0]  exp_in;
  logic        sign_in;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mantissa_out;
  logic [5:0]  k_final;
  logic [2:0]  exp_final;
  logic        sign_final;
  logic        inexact;
  logic        sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  round_norm_pipe #(.IN_W(64), .OUT_W(32), .ES(3), .K_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .shifted_mantissa (shifted_mantissa),
    .k_in             (k_in),
    .exp_in           (exp_in),
    .sign_in          (sign_in),
    .rnd_mode         (rnd_mode),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .mantissa_out     (mantissa_out),
    .k_final          (k_final),
    .exp_final        (exp_final),
    .sign_final       (sign_final),
    .inexact          (inexact),
    .sat              (sat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] m, input logic [5:0] k,
                            input logic [2:0] e, input logic s, input logic inx, input logic st);
    chk({tag, ".mant"},    64'(mantissa_out), 64'(m));
    chk({tag, ".k"},       64'(k_final),      64'(k));
    chk({tag, ".exp"},     64'(exp_final),    64'(e));
    chk({tag, ".sign"},    64'(sign_final),   64'(s));
    chk({tag, ".inexact"}, 64'(inexact),      64'(inx));
    chk({tag, ".sat"},     64'(sat),          64'(st));
  endtask

  // Present one operand in IDLE and wait (bounded) for out_valid
  task automatic issue(input string tag, input logic [63:0] sm, input logic [5:0] k,
                       input logic [2:0] e, input logic s, input logic [1:0] mode);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    shifted_mantissa = sm;
    k_in = k; exp_in = e; sign_in = s; rnd_mode = mode;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    shifted_mantissa = '0; k_in = '0; exp_in = '0; sign_in = 1'b0; rnd_mode = 2'd0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd2);
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle"},   64'(in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    shifted_mantissa = '0; k_in = '0; exp_in = '0; sign_in = 1'b0; rnd_mode = 2'd0;
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk_result("rst", 32'h0, 6'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // RNE: guard set, lsb odd -> round up
    issue("rne_up", 64'h80000001_80000000, 6'd2, 3'd5, 1'b0, 2'd0);
    chk_result("rne_up", 32'h80000002, 6'd2, 3'd5, 1'b0, 1'b1, 1'b0);
    release_out("rne_up");

    // RNE: exact tie, lsb even -> stays
    issue("rne_tie", 64'h80000000_80000000, 6'd2, 3'd5, 1'b0, 2'd0);
    chk_result("rne_tie", 32'h80000000, 6'd2, 3'd5, 1'b0, 1'b1, 1'b0);
    release_out("rne_tie");

    // Carry into exponent then regime
    issue("carry", 64'hFFFFFFFF_FFFFFFFF, 6'd2, 3'd7, 1'b0, 2'd0);
    chk_result("carry", 32'h80000000, 6'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    release_out("carry");

    // Carry from negative regime -1 to 0
    issue("carry_neg", 64'hFFFFFFFF_FFFFFFFF, 6'h3F, 3'd7, 1'b0, 2'd0);
    chk_result("carry_neg", 32'h80000000, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    release_out("carry_neg");

    // Saturation at K_MAX
    issue("sat", 64'hFFFFFFFF_FFFFFFFF, 6'd31, 3'd7, 1'b0, 2'd0);
    chk_result("sat", 32'hFFFFFFFF, 6'd31, 3'd7, 1'b0, 1'b1, 1'b1);
    release_out("sat");

    // Mode sweep, negative operand, sticky only
    issue("rtz", 64'h12345678_00000001, 6'h3D, 3'd1, 1'b1, 2'd1);
    chk_result("rtz", 32'h12345678, 6'h3D, 3'd1, 1'b1, 1'b1, 1'b0);
    release_out("rtz");
    issue("rdn", 64'h12345678_00000001, 6'h3D, 3'd1, 1'b1, 2'd3);
    chk_result("rdn", 32'h12345679, 6'h3D, 3'd1, 1'b1, 1'b1, 1'b0);
    release_out("rdn");
    issue("rup", 64'h12345678_00000001, 6'h3D, 3'd1, 1'b1, 2'd2);
    chk_result("rup", 32'h12345678, 6'h3D, 3'd1, 1'b1, 1'b1, 1'b0);
    release_out("rup");
    issue("rne", 64'h12345678_00000001, 6'h3D, 3'd1, 1'b1, 2'd0);
    chk_result("rne", 32'h12345678, 6'h3D, 3'd1, 1'b1, 1'b1, 1'b0);
    release_out("rne");

    // Zero mantissa, round-up mode, positive
    issue("zero", 64'h0, 6'd5, 3'd4, 1'b0, 2'd2);
    chk_result("zero", 32'h0, 6'd5, 3'd4, 1'b0, 1'b0, 1'b0);
    release_out("zero");

    // Back-pressure: hold 5 cycles with a stray in_valid pulse
    issue("bp", 64'h80000001_80000000, 6'd2, 3'd5, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        shifted_mantissa = 64'h55555555_55555555; k_in = 6'd9; exp_in = 3'd2;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.in_ready",  64'(in_ready),  64'd0);
      chk("bp.mant",      64'(mantissa_out), 64'h80000002);
    end
    in_valid = 1'b0;
    shifted_mantissa = '0; k_in = '0; exp_in = '0;
    release_out("bp");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp.no_extra", 64'(out_valid), 64'd0);
    end
    chk_result("bp_keep", 32'h80000002, 6'd2, 3'd5, 1'b0, 1'b1, 1'b0);

    // Reset during ROUND discards the operand
    @(negedge clk);
    shifted_mantissa = 64'hFFFFFFFF_FFFFFFFF; k_in = 6'd4; exp_in = 3'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.in_ready",  64'(in_ready),  64'd1);
    chk_result("mrst", 32'h0, 6'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst.no_ov", 64'(out_valid), 64'd0);
    end

    // Block still works after reset
    issue("post", 64'h80000001_80000000, 6'd1, 3'd6, 1'b1, 2'd1);
    chk_result("post", 32'h80000001, 6'd1, 3'd6, 1'b1, 1'b1, 1'b0);
    release_out("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
